transmitter_inform: RTL and testbench
=====================================

# transmitter_inform

Serial frame transmitter for the HO/IM1/IM0 pulse-line link. It accepts 16-bit words over a valid/ready handshake and emits one frame: an HO marker pulse followed by WORDS words. Each word is sent MSB first as 16 bit pulses, on IM1 for a 1 and on IM0 for a 0. It sits on the sending side of the link and drives the same lines the frame receiver decodes, with pulse widths chosen to clear the receiver's 21-clock qualification.

## Interface
Parameters:
- WORDS, 96: words per frame (1..127)
- HO_LEN, 32: HO high time, clocks (1..255)
- PULSE_LEN, 24: IM1/IM0 high time per bit, clocks (1..255; ≥22 for link compliance)
- GAP_LEN, 8: low time after HO and after every bit, clocks (1..255)

Ports:
- clk13MHz  in  1  system clock, 13 MHz
- nRST  in  1  reset, asynchronous, active-low
- start  in  1  frame request, sampled in IDLE only
- din  in  16  word to send
- dVal  in  1  din valid
- ready  out  1  transmitter can take din this cycle
- HO  out  1  frame marker line
- IM1  out  1  one-bit pulse line
- IM0  out  1  zero-bit pulse line
- busy  out  1  frame in progress (not IDLE)
- cntWord  out  7  words fully sent in the current frame
- TXdone  out  1  one-cycle pulse at end of frame

## Operation
- Reset (async, nRST=0): every output is 0, state=IDLE, all counters 0, and the shift register is 0. The line outputs drop in the same cycle reset asserts.
- All outputs are registered. HO, IM1 and IM0 are never high together, and the reset and idle line state is all low.
- States:
  - IDLE: on start=1, go to HOPULSE and clear cntWord. busy=1 from the next cycle.
  - HOPULSE: HO=1 for HO_LEN clocks, then go to HOGAP.
  - HOGAP: all lines low for GAP_LEN clocks, then go to LOAD.
  - LOAD: ready=1. On dVal&ready, latch din into the shift register, set cntBit=0, go to BIT. Without dVal, stay in LOAD with lines low; the gap stretches with no limit.
  - BIT: drive IM1=sr[15] if that bit is 1, else IM0=1, for PULSE_LEN clocks, then go to GAP.
  - GAP: lines low for GAP_LEN clocks, then shift sr left by 1 and increment cntBit.
    - cntBit was 15: increment cntWord. If the new cntWord equals WORDS, go to FINAL; otherwise go to LOAD.
    - Otherwise: go to BIT.
  - FINAL: TXdone=1 for one cycle, then go to IDLE.
- Clock counter: 8 bits unsigned. It loads length−1 on state entry, counts down, and the state exits when it reaches 0.
- cntWord holds its final value (WORDS) in IDLE until the next start.
- start outside IDLE is ignored. This includes the FINAL cycle.
- ready is high only in LOAD. A word offered outside LOAD is not consumed.
- Reset mid-frame aborts the frame immediately. No TXdone is issued, and the partial word is discarded.

## Timing
- The cycle start is sampled in IDLE is cycle 0.
- HO rises at cycle 1 and is high for cycles 1..HO_LEN.
- Lines are low for cycles HO_LEN+1..HO_LEN+GAP_LEN. LOAD (ready=1) begins at cycle HO_LEN+GAP_LEN+1.
- If dVal is already high, the handshake completes on that first LOAD cycle and the first IM pulse rises on the next cycle.
- Bit period is PULSE_LEN+GAP_LEN clocks, so a word takes 16×(PULSE_LEN+GAP_LEN) clocks plus handshake cycles.
- Each word has exactly one LOAD cycle minimum, so with continuous dVal there is a 1-clock extra gap between words.
- TXdone is the cycle after the last GAP clock. busy falls the cycle after TXdone.
- With defaults and continuous dVal, a frame is 1 + 32 + 8 + 96×(1+512) + 1 clocks, from start to TXdone inclusive.

## Structure
- Package bcd_link_pkg holds:
  - the state enum (IDLE, HOPULSE, HOGAP, LOAD, BIT, GAP, FINAL)
  - the default WORDS, HO_LEN, PULSE_LEN and GAP_LEN
  - the receiver qualification constant (21) that PULSE_LEN must exceed
- One sub-module, pulse_timer: 8-bit down-counter with load value, load strobe and expire output. It is reused for all HO, pulse and gap intervals.

## Test plan
- Reset values: hold nRST=0 with random inputs, then release. Expect all outputs 0. Assert nRST mid-BIT: IM1 and IM0 drop in the same cycle, and no TXdone follows.
- Single frame, WORDS=2, words 0x8001 and 0x0000, dVal held high:
  - HO high exactly 32 clocks.
  - Word 1: IM1 pulse, 14 IM0 pulses, IM1 pulse, each 24 high and 8 low.
  - Word 2: 16 IM0 pulses.
  - One-cycle TXdone, then cntWord=2.
- Loopback: default parameters, 96 random words, transmitter output feeding the frame receiver. All 96 words are reported in order and WRdone pulses once.
- Underrun: drop dVal for 100 cycles before word 3. ready is held for 100 cycles, lines stay low, and transmission resumes with word 3 intact.
- Stray start: pulse start during BIT and during FINAL. No effect, and frame length is unchanged. start on the first IDLE cycle after FINAL begins a new frame.
- Minimum lengths: HO_LEN=PULSE_LEN=GAP_LEN=1, WORDS=1, word 0xFFFF. Expect 16 single-cycle IM1 pulses separated by single low cycles, and no cycle with two lines high.

Source files
------------

// File: rtl/bcd_link_pkg.sv
// Shared types and constants for the HO/IM1/IM0 pulse-line link.
package bcd_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOPULSE,
        HOGAP,
        LOAD,
        BIT,
        GAP,
        FINAL
    } tx_state_t;

    localparam int unsigned DEF_WORDS     = 96;
    localparam int unsigned DEF_HO_LEN    = 32;
    localparam int unsigned DEF_PULSE_LEN = 24;
    localparam int unsigned DEF_GAP_LEN   = 8;

    // Receiver qualifies a pulse after this many clocks; PULSE_LEN must exceed it.
    localparam int unsigned RX_QUAL_LEN   = 21;

    localparam int unsigned TMR_W         = 8;
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned BIT_W         = 4;
    localparam int unsigned CNTW_W        = 7;

    // Timer reload value for an interval of len clocks.
    function automatic logic [TMR_W-1:0] tmr_reload(input int unsigned len);
        return TMR_W'(len - 1);
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Down-counter timing HO, pulse and gap intervals; expires when it reaches 0.
module pulse_timer
    import bcd_link_pkg::*;
(
    input  logic             clk13MHz,
    input  logic             nRST,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired_c
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk13MHz or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    assign expired_c = (cnt == '0);

endmodule

// File: rtl/transmitter_inform.sv
// Frame transmitter: HO marker pulse, then WORDS words sent MSB first as IM1/IM0 pulses.
module transmitter_inform
    import bcd_link_pkg::*;
#(
    parameter int unsigned WORDS     = DEF_WORDS,
    parameter int unsigned HO_LEN    = DEF_HO_LEN,
    parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
    parameter int unsigned GAP_LEN   = DEF_GAP_LEN
) (
    input  logic              clk13MHz,
    input  logic              nRST,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    input  logic              dVal,
    output logic              ready,
    output logic              HO,
    output logic              IM1,
    output logic              IM0,
    output logic              busy,
    output logic [CNTW_W-1:0] cntWord,
    output logic              TXdone
);

    localparam logic [TMR_W-1:0]  HO_RELOAD    = tmr_reload(HO_LEN);
    localparam logic [TMR_W-1:0]  PULSE_RELOAD = tmr_reload(PULSE_LEN);
    localparam logic [TMR_W-1:0]  GAP_RELOAD   = tmr_reload(GAP_LEN);
    localparam logic [CNTW_W-1:0] WORDS_LAST   = CNTW_W'(WORDS);

    tx_state_t          state;
    logic [WORD_W-1:0]  sr;
    logic [BIT_W-1:0]   cntBit;

    logic               tmr_load_c;
    logic [TMR_W-1:0]   tmr_val_c;
    logic               tmr_exp_c;
    logic               take_c;
    logic               last_bit_c;
    logic [CNTW_W-1:0]  next_word_c;

    assign take_c      = dVal && ready;
    assign last_bit_c  = (cntBit == BIT_W'(15));
    assign next_word_c = cntWord + CNTW_W'(1);

    // Timer reload on entry to each timed state, mirroring the FSM transitions.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state)
            IDLE:    if (start)     begin tmr_load_c = 1'b1; tmr_val_c = HO_RELOAD;    end
            HOPULSE: if (tmr_exp_c) begin tmr_load_c = 1'b1; tmr_val_c = GAP_RELOAD;   end
            LOAD:    if (take_c)    begin tmr_load_c = 1'b1; tmr_val_c = PULSE_RELOAD; end
            BIT:     if (tmr_exp_c) begin tmr_load_c = 1'b1; tmr_val_c = GAP_RELOAD;   end
            GAP: begin
                if (tmr_exp_c && !last_bit_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = PULSE_RELOAD;
                end
            end
            default: ;
        endcase
    end

    pulse_timer u_timer (
        .clk13MHz  (clk13MHz),
        .nRST      (nRST),
        .load      (tmr_load_c),
        .load_val  (tmr_val_c),
        .expired_c (tmr_exp_c)
    );

    always_ff @(posedge clk13MHz or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            sr      <= '0;
            cntBit  <= '0;
            cntWord <= '0;
            ready   <= 1'b0;
            HO      <= 1'b0;
            IM1     <= 1'b0;
            IM0     <= 1'b0;
            busy    <= 1'b0;
            TXdone  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= HOPULSE;
                        HO      <= 1'b1;
                        busy    <= 1'b1;
                        cntWord <= '0;
                    end
                end
                HOPULSE: begin
                    if (tmr_exp_c) begin
                        state <= HOGAP;
                        HO    <= 1'b0;
                    end
                end
                HOGAP: begin
                    if (tmr_exp_c) begin
                        state <= LOAD;
                        ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (take_c) begin
                        state  <= BIT;
                        ready  <= 1'b0;
                        sr     <= din;
                        cntBit <= '0;
                        IM1    <= din[WORD_W-1];
                        IM0    <= !din[WORD_W-1];
                    end
                end
                BIT: begin
                    if (tmr_exp_c) begin
                        state <= GAP;
                        IM1   <= 1'b0;
                        IM0   <= 1'b0;
                    end else begin
                        // Pulse line follows the current MSB for the whole bit.
                        IM1 <= sr[WORD_W-1];
                        IM0 <= !sr[WORD_W-1];
                    end
                end
                GAP: begin
                    if (tmr_exp_c) begin
                        sr     <= {sr[WORD_W-2:0], 1'b0};
                        cntBit <= cntBit + BIT_W'(1);
                        if (last_bit_c) begin
                            cntWord <= next_word_c;
                            if (next_word_c == WORDS_LAST) begin
                                state  <= FINAL;
                                TXdone <= 1'b1;
                            end else begin
                                state <= LOAD;
                                ready <= 1'b1;
                            end
                        end else begin
                            state <= BIT;
                            IM1   <= sr[WORD_W-2];
                            IM0   <= !sr[WORD_W-2];
                        end
                    end
                end
                FINAL: begin
                    state  <= IDLE;
                    TXdone <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter_inform.sv
// Directed bench for transmitter_inform: three instances cover WORDS=2, defaults and minimum lengths.
module tb_transmitter_inform;
    import bcd_link_pkg::*;

    logic clk13MHz = 1'b0;
    logic nRST;
    always #5 clk13MHz = ~clk13MHz;

    int checks = 0;
    int errors = 0;

    logic        start_a, dval_a, ready_a, ho_a, im1_a, im0_a, busy_a, done_a;
    logic [15:0] din_a;
    logic [6:0]  cw_a;
    logic        start_b, dval_b, ready_b, ho_b, im1_b, im0_b, busy_b, done_b;
    logic [15:0] din_b;
    logic [6:0]  cw_b;
    logic        start_m, dval_m, ready_m, ho_m, im1_m, im0_m, busy_m, done_m;
    logic [15:0] din_m;
    logic [6:0]  cw_m;

    transmitter_inform #(.WORDS(2)) u_a (
        .clk13MHz(clk13MHz), .nRST(nRST), .start(start_a), .din(din_a), .dVal(dval_a),
        .ready(ready_a), .HO(ho_a), .IM1(im1_a), .IM0(im0_a), .busy(busy_a),
        .cntWord(cw_a), .TXdone(done_a)
    );

    transmitter_inform u_b (
        .clk13MHz(clk13MHz), .nRST(nRST), .start(start_b), .din(din_b), .dVal(dval_b),
        .ready(ready_b), .HO(ho_b), .IM1(im1_b), .IM0(im0_b), .busy(busy_b),
        .cntWord(cw_b), .TXdone(done_b)
    );

    transmitter_inform #(.WORDS(1), .HO_LEN(1), .PULSE_LEN(1), .GAP_LEN(1)) u_m (
        .clk13MHz(clk13MHz), .nRST(nRST), .start(start_m), .din(din_m), .dVal(dval_m),
        .ready(ready_m), .HO(ho_m), .IM1(im1_m), .IM0(im0_m), .busy(busy_m),
        .cntWord(cw_m), .TXdone(done_m)
    );

    task automatic tick();
        @(posedge clk13MHz);
        #1;
    endtask

    // Frame capture results for instance A (cycle 0 = start sampled).
    int   a_ho_first, a_ho_cnt, a_rdy_first, a_np, a_done, a_overlap;
    logic a_busy1;
    logic a_ptype [64];
    int   a_plen  [64];
    int   a_low   [64];

    task automatic frame_a(input logic [15:0] w0, input logic [15:0] w1,
                           input bit stray_bit, input bit stray_fin);
        logic [15:0] words [2];
        int idx, run, low;
        bit hs_prev, stray_done;
        words[0] = w0; words[1] = w1;
        idx = 0; run = 0; low = 0; hs_prev = 0; stray_done = 0;
        a_ho_first = -1; a_ho_cnt = 0; a_rdy_first = -1; a_np = 0; a_done = -1;
        a_overlap = 0; a_busy1 = 1'b0;
        din_a = words[0]; dval_a = 1'b1; start_a = 1'b1;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            tick();
            start_a = 1'b0;
            if (hs_prev) begin
                idx++;
                if (idx < 2) din_a = words[idx];
            end
            hs_prev = ready_a && dval_a;
            if (cyc == 1) a_busy1 = busy_a;
            if (ho_a) begin
                a_ho_cnt++;
                if (a_ho_first < 0) a_ho_first = cyc;
            end
            if (ready_a && a_rdy_first < 0) a_rdy_first = cyc;
            if (int'(ho_a) + int'(im1_a) + int'(im0_a) > 1) a_overlap++;
            if (im1_a || im0_a) begin
                if (run == 0 && a_np < 64) begin
                    a_ptype[a_np] = im1_a;
                    a_low[a_np]   = low;
                end
                run++;
                if (stray_bit && !stray_done) begin
                    start_a = 1'b1;
                    stray_done = 1;
                end
            end else if (run > 0) begin
                if (a_np < 64) a_plen[a_np] = run;
                a_np++;
                run = 0;
            end
            if (ho_a || im1_a || im0_a) low = 0;
            else low++;
            if (done_a) begin
                a_done = cyc;
                if (stray_fin) start_a = 1'b1;
                tick();
                start_a = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            start_a = 1'($urandom); dval_a = 1'($urandom); din_a = 16'($urandom);
            start_b = 1'($urandom); dval_b = 1'($urandom); din_b = 16'($urandom);
            start_m = 1'($urandom); dval_m = 1'($urandom); din_m = 16'($urandom);
        end
        checks++;
        if ({ready_a, ho_a, im1_a, im0_a, busy_a, cw_a, done_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold_a: got %0h want 0", {ready_a, ho_a, im1_a, im0_a, busy_a, cw_a, done_a});
        end
        start_a = 0; dval_a = 0; din_a = 0;
        start_b = 0; dval_b = 0; din_b = 0;
        start_m = 0; dval_m = 0; din_m = 0;
        nRST = 1'b1;
        tick();
        checks++;
        if ({ready_a, ho_a, im1_a, im0_a, busy_a, cw_a, done_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_rel_a: got %0h want 0", {ready_a, ho_a, im1_a, im0_a, busy_a, cw_a, done_a});
        end
        checks++;
        if ({ready_b, ho_b, im1_b, im0_b, busy_b, cw_b, done_b} !== 13'd0) begin
            errors++;
            $display("FAIL reset_rel_b: got %0h want 0", {ready_b, ho_b, im1_b, im0_b, busy_b, cw_b, done_b});
        end
        checks++;
        if ({ready_m, ho_m, im1_m, im0_m, busy_m, cw_m, done_m} !== 13'd0) begin
            errors++;
            $display("FAIL reset_rel_m: got %0h want 0", {ready_m, ho_m, im1_m, im0_m, busy_m, cw_m, done_m});
        end
    endtask

    task automatic test_reset_mid_bit();
        int n, seen_done;
        din_a = 16'hFFFF; dval_a = 1'b1; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (n = 0; n < 200 && !im1_a; n++) tick();
        checks++;
        if (im1_a !== 1'b1) begin
            errors++;
            $display("FAIL midbit_reach: im1 got %b want 1 within 200 cycles", im1_a);
        end
        for (int i = 0; i < 5; i++) tick();
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({ho_a, im1_a, im0_a, ready_a, busy_a, cw_a} !== 12'd0) begin
            errors++;
            $display("FAIL midbit_drop: got %0h want 0", {ho_a, im1_a, im0_a, ready_a, busy_a, cw_a});
        end
        tick();
        tick();
        nRST = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (done_a || im1_a || im0_a || ho_a) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL midbit_quiet: got %0d active cycles want 0", seen_done);
        end
        dval_a = 1'b0;
    endtask

    task automatic test_frame();
        logic et;
        int   elow;
        frame_a(16'h8001, 16'h0000, 0, 0);
        checks++;
        if (a_busy1 !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b want 1", a_busy1); end
        checks++;
        if (a_ho_first != 1 || a_ho_cnt != 32) begin
            errors++;
            $display("FAIL frame_ho: first %0d len %0d want 1 32", a_ho_first, a_ho_cnt);
        end
        checks++;
        if (a_rdy_first != 41) begin errors++; $display("FAIL frame_ready: got %0d want 41", a_rdy_first); end
        checks++;
        if (a_np != 32) begin errors++; $display("FAIL frame_npulse: got %0d want 32", a_np); end
        for (int i = 0; i < 32 && i < a_np; i++) begin
            et   = (i == 0 || i == 15) ? 1'b1 : 1'b0;
            elow = (i == 0 || i == 16) ? 9 : 8;
            checks++;
            if (a_ptype[i] !== et || a_plen[i] != 24 || a_low[i] != elow) begin
                errors++;
                $display("FAIL frame_pulse%0d: im1 %b len %0d low %0d want %b 24 %0d",
                         i, a_ptype[i], a_plen[i], a_low[i], et, elow);
            end
        end
        checks++;
        if (a_done != 1067) begin errors++; $display("FAIL frame_done_cyc: got %0d want 1067", a_done); end
        checks++;
        if ({busy_a, done_a, cw_a} !== {1'b0, 1'b0, 7'd2}) begin
            errors++;
            $display("FAIL frame_after: busy %b done %b cw %0d want 0 0 2", busy_a, done_a, cw_a);
        end
        checks++;
        if (a_overlap != 0) begin errors++; $display("FAIL frame_overlap: got %0d want 0", a_overlap); end
    endtask

    task automatic test_stray_start();
        frame_a(16'h8001, 16'h0000, 1, 1);
        checks++;
        if (a_done != 1067 || a_ho_cnt != 32 || a_np != 32) begin
            errors++;
            $display("FAIL stray_len: done %0d ho %0d np %0d want 1067 32 32", a_done, a_ho_cnt, a_np);
        end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL stray_idle: busy got %b want 0", busy_a); end
        frame_a(16'hFFFF, 16'h0000, 0, 0);
        checks++;
        if (a_ho_first != 1 || a_done != 1067) begin
            errors++;
            $display("FAIL stray_restart: ho_first %0d done %0d want 1 1067", a_ho_first, a_done);
        end
        checks++;
        if (cw_a !== 7'd2) begin errors++; $display("FAIL stray_cw: got %0d want 2", cw_a); end
        dval_a = 1'b0;
    endtask

    task automatic test_min_lengths();
        logic eho, eim1, edone;
        din_m = 16'hFFFF; dval_m = 1'b1; start_m = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            start_m = 1'b0;
            eho   = (cyc == 1);
            eim1  = (cyc >= 4 && cyc <= 34 && (cyc % 2) == 0);
            edone = (cyc == 36);
            checks++;
            if ({ho_m, im1_m, im0_m, done_m} !== {eho, eim1, 1'b0, edone}) begin
                errors++;
                $display("FAIL min_cyc%0d: ho/im1/im0/done got %b%b%b%b want %b%b0%b",
                         cyc, ho_m, im1_m, im0_m, done_m, eho, eim1, edone);
            end
        end
        checks++;
        if ({busy_m, cw_m} !== {1'b0, 7'd1}) begin
            errors++;
            $display("FAIL min_after: busy %b cw %0d want 0 1", busy_m, cw_m);
        end
        dval_m = 1'b0;
    endtask

    task automatic test_loopback_underrun();
        logic [15:0] sent [96];
        logic [15:0] got [$];
        logic [15:0] shreg;
        logic cur;
        int idx, run, nb, bad_len, ndone, done_cyc, stall_cnt, stall_lines, ready_drop, ovl;
        bit hs_prev;
        for (int i = 0; i < 96; i++) sent[i] = 16'($urandom);
        idx = 0; run = 0; nb = 0; bad_len = 0; ndone = 0; done_cyc = -1;
        stall_cnt = 0; stall_lines = 0; ready_drop = 0; ovl = 0; hs_prev = 0;
        shreg = '0; cur = 1'b0;
        din_b = sent[0]; dval_b = 1'b1; start_b = 1'b1;
        for (int cyc = 1; cyc < 60000; cyc++) begin
            tick();
            start_b = 1'b0;
            if (hs_prev) begin
                idx++;
                if (idx < 96) din_b = sent[idx];
                if (idx == 2) dval_b = 1'b0;
            end
            if (idx == 2 && !dval_b) begin
                if (ready_b) begin
                    if (stall_cnt == 100) dval_b = 1'b1;
                    else begin
                        stall_cnt++;
                        if (ho_b || im1_b || im0_b) stall_lines++;
                    end
                end else if (stall_cnt > 0) begin
                    ready_drop++;
                end
            end
            hs_prev = ready_b && dval_b;
            if (int'(ho_b) + int'(im1_b) + int'(im0_b) > 1) ovl++;
            if (im1_b || im0_b) begin
                if (run == 0) cur = im1_b;
                run++;
            end else if (run > 0) begin
                if (run != 24) bad_len++;
                if (run > int'(RX_QUAL_LEN)) begin
                    shreg = {shreg[14:0], cur};
                    nb++;
                    if (nb == 16) begin
                        got.push_back(shreg);
                        nb = 0;
                    end
                end
                run = 0;
            end
            if (done_b) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        checks++;
        if (got.size() != 96) begin errors++; $display("FAIL loop_count: got %0d words want 96", got.size()); end
        for (int i = 0; i < 96 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== sent[i]) begin
                errors++;
                $display("FAIL loop_word%0d: got %h want %h", i, got[i], sent[i]);
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL loop_done_count: got %0d want 1", ndone); end
        checks++;
        if (done_cyc != 49389) begin errors++; $display("FAIL loop_done_cyc: got %0d want 49389", done_cyc); end
        checks++;
        if (bad_len != 0) begin errors++; $display("FAIL loop_pulse_len: got %0d bad want 0", bad_len); end
        checks++;
        if (stall_cnt != 100 || stall_lines != 0 || ready_drop != 0) begin
            errors++;
            $display("FAIL underrun: stall %0d lines %0d drops %0d want 100 0 0", stall_cnt, stall_lines, ready_drop);
        end
        checks++;
        if (ovl != 0) begin errors++; $display("FAIL loop_overlap: got %0d want 0", ovl); end
        checks++;
        if ({busy_b, cw_b} !== {1'b0, 7'd96}) begin
            errors++;
            $display("FAIL loop_after: busy %b cw %0d want 0 96", busy_b, cw_b);
        end
        dval_b = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        start_a = 0; dval_a = 0; din_a = 0;
        start_b = 0; dval_b = 0; din_b = 0;
        start_m = 0; dval_m = 0; din_m = 0;
        test_reset();
        test_reset_mid_bit();
        test_frame();
        test_stray_start();
        test_min_lengths();
        test_loopback_underrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
